// File: rtl/aes_dma.sv
// aes_dma: streams nblocks 128-bit blocks from the AES buffer RAM through aes_core and back.
// Optional CBC chaining when AES_CBC_EN is defined; the default build is ECB.

// aes_core: iterative reversible block transform with the init/valid_out handshake of the AES core.
module aes_core (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         init_in,
    input  logic         mode_in,
    input  logic [127:0] key_in,
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         valid_out
);
    localparam int unsigned NR = 4;

    logic [127:0] st;
    logic [127:0] key;
    logic         mode;
    logic         run;
    logic [1:0]   rnd;
    logic [1:0]   ridx;
    logic [7:0]   sh;
    logic [127:0] rk;
    logic [127:0] x;
    logic [127:0] step;

    // Decrypt walks the round keys in reverse order, undoing each encrypt round.
    always_comb begin
        ridx = mode ? 2'(NR - 1) - rnd : rnd;
        sh   = {3'b000, ridx, 3'b000};
        rk   = (key << sh) | (key >> (8'd128 - sh));
        x    = st ^ rk;
        step = mode ? ({st[12:0], st[127:13]} ^ rk) : {x[114:0], x[127:115]};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            st        <= '0;
            key       <= '0;
            mode      <= 1'b0;
            run       <= 1'b0;
            rnd       <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (init_in) begin
                st   <= data_in;
                key  <= key_in;
                mode <= mode_in;
                run  <= 1'b1;
                rnd  <= '0;
            end else if (run) begin
                st  <= step;
                rnd <= rnd + 2'd1;
                if (rnd == 2'(NR - 1)) begin
                    run       <= 1'b0;
                    valid_out <= 1'b1;
                end
            end
        end
    end

    assign data_out = st;
endmodule

module aes_dma #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned IN_BASE    = 0,
    parameter int unsigned OUT_BASE   = 257,
    parameter int unsigned MAX_BLOCKS = 64,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              start_in,
    input  logic                              mode_in,
    input  logic [$clog2(MAX_BLOCKS+1)-1:0]   nblocks_in,
    input  logic [127:0]                      key_in,
    input  logic [127:0]                      iv_in,
    output logic [ADDR_W-1:0]                 mem_addr_out,
    output logic [3:0]                        mem_we_out,
    output logic [31:0]                       mem_data_out,
    input  logic [31:0]                       mem_data_in,
    output logic                              busy_out,
    output logic                              done_out,
    output logic                              err_out
);
    localparam int unsigned NB_W  = $clog2(MAX_BLOCKS + 1);
    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, CORE_START, CORE_WAIT, WB, DONE} state_t;

    state_t          state;
    logic            mode;
    logic [NB_W-1:0] count;
    logic [NB_W-1:0] b;
    logic [1:0]      w;
    logic [LAT_W-1:0] lat;
    logic [127:0]    key;
    logic [127:0]    blk;
    logic [127:0]    res;
    logic            core_init;
    logic            core_valid;
    logic [127:0]    core_in;
    logic [127:0]    core_out;
    logic [127:0]    result;

    function automatic logic [ADDR_W-1:0] word_addr(input int unsigned base,
                                                    input logic [NB_W-1:0] blk_i,
                                                    input logic [1:0] wi);
        return ADDR_W'(base + 32'(blk_i) * 4 + 32'(wi));
    endfunction

    function automatic logic [31:0] lane(input logic [127:0] v, input logic [1:0] i);
        return v[32*(3-i) +: 32];
    endfunction

`ifdef AES_CBC_EN
    logic [127:0] chain;
    assign core_in = mode ? blk : (blk ^ chain);
    assign result  = mode ? (core_out ^ chain) : core_out;
`else
    logic unused_iv;
    assign unused_iv = ^iv_in;
    assign core_in   = blk;
    assign result    = core_out;
`endif

    assign core_init = (state == CORE_START);

    aes_core u_core (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .init_in   (core_init),
        .mode_in   (mode),
        .key_in    (key),
        .data_in   (core_in),
        .data_out  (core_out),
        .valid_out (core_valid)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            mode         <= 1'b0;
            count        <= '0;
            b            <= '0;
            w            <= '0;
            lat          <= '0;
            key          <= '0;
            blk          <= '0;
            res          <= '0;
            mem_addr_out <= ADDR_W'(IN_BASE);
            mem_we_out   <= '0;
            mem_data_out <= '0;
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
            err_out      <= 1'b0;
`ifdef AES_CBC_EN
            chain        <= '0;
`endif
        end else begin
            done_out <= 1'b0;
            err_out  <= 1'b0;
            unique case (state)
                IDLE: if (start_in) begin
                    if (nblocks_in == '0 || 32'(nblocks_in) > MAX_BLOCKS) begin
                        err_out <= 1'b1;
                    end else begin
                        mode         <= mode_in;
                        count        <= nblocks_in;
                        key          <= key_in;
                        b            <= '0;
                        w            <= '0;
                        busy_out     <= 1'b1;
                        mem_addr_out <= word_addr(IN_BASE, '0, 2'd0);
                        state        <= RD_ISSUE;
`ifdef AES_CBC_EN
                        chain        <= iv_in;
`endif
                    end
                end
                RD_ISSUE: begin
                    lat   <= '0;
                    state <= RD_WAIT;
                end
                RD_WAIT: if (lat == LAT_W'(RD_LAT - 1)) begin
                    blk[32*(3-w) +: 32] <= mem_data_in;
                    if (w == 2'd3) begin
                        w     <= '0;
                        state <= CORE_START;
                    end else begin
                        w            <= w + 2'd1;
                        mem_addr_out <= word_addr(IN_BASE, b, w + 2'd1);
                        state        <= RD_ISSUE;
                    end
                end else begin
                    lat <= lat + 1'b1;
                end
                CORE_START: state <= CORE_WAIT;
                // Lane 0 is taken straight from the core so the write burst starts without a bubble.
                CORE_WAIT: if (core_valid) begin
                    res          <= result;
                    mem_addr_out <= word_addr(OUT_BASE, b, 2'd0);
                    mem_we_out   <= '1;
                    mem_data_out <= lane(result, 2'd0);
                    state        <= WB;
`ifdef AES_CBC_EN
                    chain        <= mode ? blk : core_out;
`endif
                end
                WB: if (w == 2'd3) begin
                    mem_we_out   <= '0;
                    mem_data_out <= '0;
                    w            <= '0;
                    b            <= b + 1'b1;
                    if ((b + 1'b1) == count) begin
                        done_out <= 1'b1;
                        busy_out <= 1'b0;
                        state    <= DONE;
                    end else begin
                        mem_addr_out <= word_addr(IN_BASE, b + 1'b1, 2'd0);
                        state        <= RD_ISSUE;
                    end
                end else begin
                    w            <= w + 2'd1;
                    mem_addr_out <= word_addr(OUT_BASE, b, w + 2'd1);
                    mem_data_out <= lane(res, w + 2'd1);
                end
                DONE: begin
                    mem_addr_out <= ADDR_W'(IN_BASE);
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
